// File: rtl/grid_encoder.sv
// grid_encoder: front-end writer for the input grid.
//
// Two raw push-buttons are synchronized and debounced. NEXT cycles the
// selected character O -> U -> I -> O; LOAD writes the selected character
// into INPUT_GRID_0..8 as nine (8,5) fixed-point values over a valid/ready
// register-write port.
//
// Ports:
//   CLK, RSTN              clock, synchronous active-low reset
//   BTN_NEXT, BTN_LOAD     raw asynchronous buttons
//   GRID_WE/IDX/DATA       write request (valid, register index, value)
//   GRID_READY             register pool accepts on GRID_WE && GRID_READY
//   CHAR_SEL               selected character (0=O, 1=U, 2=I)
//   BUSY                   high while the write sequence runs
//   DONE                   one-cycle pulse after the last write is accepted
//
// Optional feature: define GRID_ENCODER_AUTOLOAD_EN to make a NEXT press
// start a write of the newly selected character on the following cycle.

module grid_encoder #(
    parameter int unsigned DEBOUNCE_WIDTH = 20
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       BTN_NEXT,
    input  logic       BTN_LOAD,
    output logic       GRID_WE,
    output logic [3:0] GRID_IDX,
    output logic [7:0] GRID_DATA,
    input  logic       GRID_READY,
    output logic [1:0] CHAR_SEL,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [7:0] PosOne = 8'h20;
    localparam logic [7:0] NegOne = 8'he0;
    localparam logic [DEBOUNCE_WIDTH-1:0] CntOne = 1;

    typedef enum logic [1:0] {StIdle, StWrite, StFinish} state_e;

    // Element k of a pattern; a set mask bit marks a -1 element.
    function automatic logic [7:0] pattern_elem(input logic [1:0] ch, input logic [3:0] k);
        logic [8:0] neg_mask;
        case (ch)
            2'd1:    neg_mask = 9'b010010000;  // U: e4, e7
            2'd2:    neg_mask = 9'b111101101;  // I: all but e1, e4
            default: neg_mask = 9'b000010000;  // O: e4
        endcase
        return neg_mask[k] ? NegOne : PosOne;
    endfunction

    // ------------------------------------------------------------------
    // Synchronizers and debouncers; bit 0 = NEXT, bit 1 = LOAD.
    // ------------------------------------------------------------------
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] deb_q, deb_d;
    logic [1:0] deb_prev_q, deb_prev_d;
    logic [1:0] evt_q, evt_d;
    logic [DEBOUNCE_WIDTH-1:0] cnt_q [2];
    logic [DEBOUNCE_WIDTH-1:0] cnt_d [2];

    always_comb begin
        sync1_d    = {BTN_LOAD, BTN_NEXT};
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        // Press event is registered one cycle after the debounced rise.
        evt_d      = deb_q & ~deb_prev_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (&cnt_q[i]) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            evt_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            evt_q      <= evt_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Selector and write FSM, all outputs registered.
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic       we_q, we_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] pat_q, pat_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    // Pending write of the freshly advanced character; never set unless
    // the autoload feature is built in.
    logic       auto_q, auto_d;
    logic       handshake;
    logic       next_evt;
    logic       load_evt;

    assign handshake = we_q && GRID_READY;
    assign next_evt  = evt_q[0];
    assign load_evt  = evt_q[1];

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        idx_d   = idx_q;
        data_d  = data_q;
        sel_d   = sel_q;
        pat_d   = pat_q;
        busy_d  = busy_q;
        done_d  = done_q;
        auto_d  = auto_q;

        case (state_q)
            StIdle: begin
                // LOAD beats NEXT and a pending autoload; the current
                // selection is used and any NEXT this cycle is dropped.
                if (load_evt || auto_q) begin
                    state_d = StWrite;
                    pat_d   = sel_q;
                    we_d    = 1'b1;
                    idx_d   = 4'd0;
                    data_d  = pattern_elem(sel_q, 4'd0);
                    busy_d  = 1'b1;
                    auto_d  = 1'b0;
                end else if (next_evt) begin
                    sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
`ifdef GRID_ENCODER_AUTOLOAD_EN
                    auto_d = 1'b1;
`else
                    auto_d = 1'b0;
`endif
                end
            end
            StWrite: begin
                if (handshake) begin
                    if (idx_q != 4'd8) begin
                        idx_d  = idx_q + 4'd1;
                        data_d = pattern_elem(pat_q, idx_q + 4'd1);
                    end else begin
                        state_d = StFinish;
                        we_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
                done_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                we_d    = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            idx_q   <= 4'd0;
            data_q  <= 8'h00;
            sel_q   <= 2'd0;
            pat_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            auto_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            pat_q   <= pat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            auto_q  <= auto_d;
        end
    end

    assign GRID_WE   = we_q;
    assign GRID_IDX  = idx_q;
    assign GRID_DATA = data_q;
    assign CHAR_SEL  = sel_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule
